// File: rtl/act_sram_reader.sv
// Burst reader: streams `length` words from a 1-cycle-latency SRAM into a
// 2-entry ready/valid output FIFO. Optional stride port under ACT_RD_STRIDE_EN.
module act_sram_reader (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] base_addr,
    input  logic [12:0] length,
`ifdef ACT_RD_STRIDE_EN
    input  logic [11:0] stride,
`endif
    output logic        busy,
    output logic        done,
    output logic        sram_cen,
    output logic [3:0]  sram_wea,
    output logic [15:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic        m_last
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] addr_q, addr_d;
    logic [12:0] len_q, len_d;
    logic [12:0] issued_q, issued_d;
    logic        done_q, done_d;
    logic        inflight_q, inflight_d;
    logic        inflightLast_q, inflightLast_d;

    logic [31:0] fifoData_q [2];
    logic        fifoLast_q [2];
    logic        wrPtr_q, rdPtr_q;
    logic [1:0]  count_q;

    logic [11:0] step;
    logic        pop, push, issue, lastIssue, headLast;
    logic [2:0]  occAfterPop;
    logic        unused_base;

`ifdef ACT_RD_STRIDE_EN
    logic [11:0] step_q, step_d;
    assign step = step_q;
`else
    assign step = 12'd1;
`endif

    assign unused_base = ^base_addr[15:12];

    assign pop         = (count_q != 2'd0) && m_ready;
    assign push        = inflight_q;
    assign headLast    = fifoLast_q[rdPtr_q];
    assign lastIssue   = (issued_q == (len_q - 13'd1));
    // Reads are throttled so buffered plus in-flight words never exceed the FIFO depth.
    assign occAfterPop = {1'b0, count_q} - {2'b00, pop} + {2'b00, inflight_q};
    assign issue       = (state_q == RUN) && (occAfterPop < 3'd2);

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        len_d          = len_q;
        issued_d       = issued_q;
        done_d         = 1'b0;
        inflight_d     = issue;
        inflightLast_d = issue && lastIssue;
`ifdef ACT_RD_STRIDE_EN
        step_d         = step_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length != 13'd0) begin
                        state_d  = RUN;
                        addr_d   = base_addr[11:0];
                        len_d    = length;
                        issued_d = 13'd0;
`ifdef ACT_RD_STRIDE_EN
                        step_d   = stride;
`endif
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    addr_d   = addr_q + step;
                    issued_d = issued_q + 13'd1;
                    if (lastIssue) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && headLast) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            addr_q         <= 12'd0;
            len_q          <= 13'd0;
            issued_q       <= 13'd0;
            done_q         <= 1'b0;
            inflight_q     <= 1'b0;
            inflightLast_q <= 1'b0;
`ifdef ACT_RD_STRIDE_EN
            step_q         <= 12'd0;
`endif
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            len_q          <= len_d;
            issued_q       <= issued_d;
            done_q         <= done_d;
            inflight_q     <= inflight_d;
            inflightLast_q <= inflightLast_d;
`ifdef ACT_RD_STRIDE_EN
            step_q         <= step_d;
`endif
        end
    end

    // SRAM data is only valid the cycle after an issued read, so capture is keyed on inflight_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifoData_q[0] <= 32'h0;
            fifoData_q[1] <= 32'h0;
            fifoLast_q[0] <= 1'b0;
            fifoLast_q[1] <= 1'b0;
            wrPtr_q       <= 1'b0;
            rdPtr_q       <= 1'b0;
            count_q       <= 2'd0;
        end else begin
            if (push) begin
                fifoData_q[wrPtr_q] <= sram_rdata;
                fifoLast_q[wrPtr_q] <= inflightLast_q;
                wrPtr_q             <= ~wrPtr_q;
            end
            if (pop) begin
                rdPtr_q <= ~rdPtr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign sram_cen   = ~issue;
    assign sram_addr  = issue ? {4'b0000, addr_q} : 16'h0000;
    assign sram_wea   = 4'b0000;
    assign sram_wdata = 32'h0;
    assign m_valid    = (count_q != 2'd0);
    assign m_data     = m_valid ? fifoData_q[rdPtr_q] : 32'h0;
    assign m_last     = m_valid && fifoLast_q[rdPtr_q];

endmodule

// File: tb/tb_act_sram_reader.sv
// Scoreboard bench for act_sram_reader: bursts are expanded into expected address
// and data queues at launch; a negedge monitor pops and compares DUT activity.
module tb_act_sram_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic [12:0] length;
`ifdef ACT_RD_STRIDE_EN
    logic [11:0] stride;
`endif
    logic        busy, done, sram_cen, m_valid, m_last, m_ready;
    logic [3:0]  sram_wea;
    logic [15:0] sram_addr;
    logic [31:0] sram_wdata, sram_rdata, m_data;

    act_sram_reader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .length     (length),
`ifdef ACT_RD_STRIDE_EN
        .stride     (stride),
`endif
        .busy       (busy),
        .done       (done),
        .sram_cen   (sram_cen),
        .sram_wea   (sram_wea),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // SRAM model: one-cycle read latency, junk on the bus in every other cycle.
    logic [31:0] mem [4096];
    logic        rdValid = 1'b0;
    logic [31:0] rdWord, junk;
    assign sram_rdata = rdValid ? rdWord : junk;

    always @(posedge clk) begin
        rdValid <= !sram_cen;
        rdWord  <= mem[sram_addr[11:0]];
        junk    <= $urandom;
        cyc     <= cyc + 1;
    end

    // Downstream ready: 0 = always, 1 = pattern 1,0,0,1, 2 = random.
    int readyMode = 0;
    int readyPhase = 0;
    always @(posedge clk) begin
        #1;
        case (readyMode)
            0: m_ready = 1'b1;
            1: m_ready = (readyPhase == 0) || (readyPhase == 3);
            default: m_ready = ($urandom_range(0, 1) == 1);
        endcase
        readyPhase = (readyPhase + 1) % 4;
    end

    logic [11:0] addrQ [$];
    logic [31:0] dataQ [$];
    logic        lastQ [$];
    int  issuedCnt = 0, poppedCnt = 0;
    int  startCycle = 0, burstLen = 0, doneExpCycle = -1;
    int  hsFirst = 0, hsLast = 0;
    bit  doneArmed = 0, doneSeen = 0;
    bit  holdPrev = 0;
    logic [31:0] prevData;
    logic        prevLast;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares SRAM requests, stream words, busy and done against the queues.
    always @(negedge clk) begin
        logic [11:0] expA;
        logic [31:0] expD;
        logic        expL;
        bit          busyExp;
        if (rst) begin
            addrQ.delete();
            dataQ.delete();
            lastQ.delete();
            issuedCnt = 0;
            poppedCnt = 0;
            doneArmed = 0;
            holdPrev  = 0;
        end else begin
            checkOutput("sram_write_side", {sram_wea, sram_wdata[27:0]} | {28'h0, sram_wdata[31:28]}, 32'h0);
            if (!sram_cen) begin
                issuedCnt++;
                if (addrQ.size() == 0) begin
                    checkOutput("unexpected_read", {16'h0, sram_addr}, 32'hFFFFFFFF);
                end else begin
                    expA = addrQ.pop_front();
                    checkOutput("sram_addr", {16'h0, sram_addr}, {20'h0, expA});
                end
            end else begin
                checkOutput("sram_addr_idle", {16'h0, sram_addr}, 32'h0);
            end
            if (holdPrev) begin
                checkOutput("hold_valid", {31'h0, m_valid}, 32'h1);
                checkOutput("hold_data", m_data, prevData);
                checkOutput("hold_last", {31'h0, m_last}, {31'h0, prevLast});
            end
            if (m_valid && m_ready) begin
                if (poppedCnt == 0) hsFirst = cyc;
                hsLast = cyc;
                poppedCnt++;
                if (dataQ.size() == 0) begin
                    checkOutput("unexpected_word", m_data, 32'hDEADBEEF ^ m_data ^ 32'h1);
                end else begin
                    expD = dataQ.pop_front();
                    expL = lastQ.pop_front();
                    checkOutput("m_data", m_data, expD);
                    checkOutput("m_last", {31'h0, m_last}, {31'h0, expL});
                    if (expL) doneExpCycle = cyc + 1;
                end
            end
            holdPrev = m_valid && !m_ready;
            prevData = m_data;
            prevLast = m_last;
            checkOutput("outstanding_le_2", {31'h0, (issuedCnt - poppedCnt) <= 2}, 32'h1);
            busyExp = doneArmed && (burstLen != 0) && (cyc > startCycle) && (cyc != doneExpCycle);
            checkOutput("busy", {31'h0, busy}, {31'h0, busyExp});
            if (done) begin
                checkOutput("done_timing", cyc, doneArmed ? doneExpCycle : -1);
                doneArmed = 0;
                doneSeen  = 1;
            end else if (doneArmed && cyc == doneExpCycle) begin
                checkOutput("done_missing", {31'h0, done}, 32'h1);
                doneArmed = 0;
                doneSeen  = 1;
            end
        end
    end

    task automatic launchBurst(input logic [15:0] base, input int len, input int stp, input int mode);
        int a;
        @(posedge clk);
        #1;
        readyMode = mode;
        for (int i = 0; i < len; i++) begin
            a = (int'(base[11:0]) + i * stp) % 4096;
            addrQ.push_back(a[11:0]);
            dataQ.push_back(mem[a]);
            lastQ.push_back(i == len - 1);
        end
        issuedCnt    = 0;
        poppedCnt    = 0;
        startCycle   = cyc;
        burstLen     = len;
        doneExpCycle = (len == 0) ? cyc + 1 : -1;
        doneSeen     = 0;
        doneArmed    = 1;
        start        = 1'b1;
        base_addr    = base;
        length       = len[12:0];
`ifdef ACT_RD_STRIDE_EN
        stride       = stp[11:0];
`endif
        @(posedge clk);
        #1;
        start     = 1'b0;
        base_addr = 16'($urandom);
        length    = 13'($urandom);
`ifdef ACT_RD_STRIDE_EN
        stride    = 12'($urandom);
`endif
    endtask

    task automatic applyStimulus(input logic [15:0] base, input int len, input int stp, input int mode);
        int budget;
        launchBurst(base, len, stp, mode);
        budget = len * 4 + 20;
        for (int n = 0; n < budget && !doneSeen; n++) begin
            @(posedge clk);
            #1;
            start = busy && ($urandom_range(0, 7) == 0);
        end
        start = 1'b0;
        if (!doneSeen) begin
            checkOutput("done_timeout", 32'h0, 32'h1);
            doneArmed = 0;
        end
        checkOutput("words_left", dataQ.size(), 0);
        checkOutput("reads_left", addrQ.size(), 0);
        if (mode == 0 && len > 0) begin
            checkOutput("back_to_back", hsLast - hsFirst, len - 1);
            checkOutput("first_latency_ge_2", {31'h0, (hsFirst - startCycle) >= 2}, 32'h1);
        end
    endtask

    task automatic applyResetMidBurst();
        bit found = 0;
        launchBurst(16'h0100, 16, 1, 0);
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            #1;
            if (m_valid && poppedCnt == 2) begin
                found = 1;
                break;
            end
        end
        checkOutput("third_word_seen", {31'h0, found}, 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst_m_valid", {31'h0, m_valid}, 32'h0);
        checkOutput("rst_busy", {31'h0, busy}, 32'h0);
        checkOutput("rst_sram_cen", {31'h0, sram_cen}, 32'h1);
        checkOutput("rst_m_data", m_data, 32'h0);
        repeat (20) @(posedge clk);
    endtask

    initial begin
        int len, mode, stp;
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = 16'h0;
        length    = 13'h0;
        m_ready   = 1'b1;
`ifdef ACT_RD_STRIDE_EN
        stride    = 12'h0;
`endif
        for (int n = 0; n < 4096; n++) mem[n] = n;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset_busy", {31'h0, busy}, 32'h0);
        checkOutput("reset_done", {31'h0, done}, 32'h0);
        checkOutput("reset_sram_cen", {31'h0, sram_cen}, 32'h1);
        checkOutput("reset_sram_addr", {16'h0, sram_addr}, 32'h0);
        checkOutput("reset_m_valid", {31'h0, m_valid}, 32'h0);
        checkOutput("reset_m_last", {31'h0, m_last}, 32'h0);
        checkOutput("reset_m_data", m_data, 32'h0);

        applyStimulus(16'h0010, 4, 1, 0);
        applyStimulus(16'h0FFE, 4, 1, 0);
        applyStimulus(16'h0020, 8, 1, 1);
        applyStimulus(16'h0030, 0, 1, 0);
        applyResetMidBurst();
        applyStimulus(16'h0200, 16, 1, 0);
`ifdef ACT_RD_STRIDE_EN
        applyStimulus(16'h0000, 3, 64, 0);
        applyStimulus(16'h0123, 5, 0, 1);
`endif

        for (int n = 0; n < 4096; n++) mem[n] = $urandom;
        for (int t = 0; t < 30; t++) begin
            len  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 40);
            mode = $urandom_range(0, 2);
`ifdef ACT_RD_STRIDE_EN
            stp  = $urandom_range(0, 4095);
`else
            stp  = 1;
`endif
            applyStimulus(16'($urandom), len, stp, mode);
        end
        applyStimulus(16'hF7A5, 4096, 1, 0);
        repeat (5) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/act_sram_reader.md
ACT_SRAM_READER -- requirements
Module: act_sram_reader

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all logic.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-004 SHALL have port: base_addr  input  16  first word address, latched on accepted start.
REQ-005 SHALL have port: length  input  13  word count 0..4096, latched on accepted start.
REQ-006 SHALL have port: busy  output  1  high from the cycle after an accepted start through the cycle before done.
REQ-007 SHALL have port: done  output  1  one-cycle pulse when the burst completes.
REQ-008 SHALL have port: sram_cen  output  1  active-low SRAM chip enable; low only in read-issue cycles.
REQ-009 SHALL have port: sram_wea  output  4  byte write enables; constant 4'b0000.
REQ-010 SHALL have port: sram_addr  output  16  SRAM word address.
REQ-011 SHALL have port: sram_wdata  output  32  constant 32'h0.
REQ-012 SHALL have port: sram_rdata  input  32  SRAM read data, valid exactly one cycle after a cycle with sram_cen low.
REQ-013 SHALL have port: m_valid  output  1  output stream word valid.
REQ-014 SHALL have port: m_ready  input  1  downstream ready.
REQ-015 SHALL have port: m_data  output  32  output stream word.
REQ-016 SHALL have port: m_last  output  1  marks the final word of the burst; qualified by m_valid.

Function
REQ-017 SHALL implement states IDLE, RUN, DRAIN; IDLE->RUN on start with length!=0; IDLE stays IDLE with a done pulse the next cycle on start with length==0; RUN->DRAIN in the cycle after the last read is issued; DRAIN->IDLE with done high in the cycle after the final m_valid&m_ready handshake.
REQ-018 SHALL ignore start while not in IDLE.
REQ-019 SHALL compute word address i as (base_addr[11:0] + i*STEP) mod 4096, with sram_addr[15:12] = 4'b0000 and base_addr[15:12] ignored.
REQ-020 SHALL capture sram_rdata into a 2-entry output FIFO in the cycle after each issued read, never sampling sram_rdata in any other cycle.
REQ-021 SHALL issue a read in a RUN cycle only when (FIFO occupancy after this cycle's pop) + (reads in flight) < 2, guaranteeing no FIFO overflow.
REQ-022 SHALL sustain one word per cycle while m_ready is held high; first m_valid no earlier than two cycles after the accepted start.
REQ-023 SHALL hold m_data, m_last, m_valid stable while m_valid=1 and m_ready=0.
REQ-024 SHALL deliver exactly length words, in address order, with m_last=1 on word length-1 only.
REQ-025 SHALL present sram_cen=1 and sram_addr=16'h0 in cycles without a read.

Reset
REQ-026 SHALL on rst drive, from the next edge: state IDLE, busy=0, done=0, sram_cen=1, sram_addr=0, m_valid=0, m_last=0, m_data=0, FIFO empty.
REQ-027 SHALL on rst mid-burst discard all in-flight and buffered words and emit no done pulse.

Configuration
REQ-028 SHALL, when ACT_RD_STRIDE_EN is defined, add port stride  input  12  word stride latched on accepted start, and use STEP = stride (stride 0 rereads base_addr length times).
REQ-029 SHALL, when ACT_RD_STRIDE_EN is undefined, omit the stride port and use STEP = 1.

Verification
REQ-030 SHALL verify: base_addr=16'h0010, length=4, m_ready=1, SRAM preloaded addr n = n -> m_data 0x10,0x11,0x12,0x13 on consecutive cycles, m_last on 0x13, done one cycle after.
REQ-031 SHALL verify: base_addr=16'h0FFE, length=4 -> sram_addr sequence 0x0FFE,0x0FFF,0x0000,0x0001 and matching data.
REQ-032 SHALL verify: length=8, m_ready toggling 1,0,0,1 repeating -> all 8 words delivered in order, no loss or duplication, never more than 2 reads outstanding+buffered.
REQ-033 SHALL verify: start with length=0 -> sram_cen stays 1, no m_valid, done pulses one cycle after start.
REQ-034 SHALL verify: rst asserted on the 3rd word of a 16-word burst -> next cycle m_valid=0, busy=0, sram_cen=1, no done; a new burst afterwards completes normally.
REQ-035 SHALL verify (ACT_RD_STRIDE_EN): base_addr=0, stride=64, length=3 -> sram_addr 0x000,0x040,0x080.
